// File: rtl/uart_word_tx.sv
// 8N1 UART transmitter that sends 32-bit words of four chars, MSB byte first, through a 2-entry word FIFO.
// Define UART_TX_NEWLINE_EN to append 0x0A after each word as a fifth frame.
module uart_word_tx #(
  parameter int CLK_HZ = 100000000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        tx,
  output logic        busy
);
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_TX_NEWLINE_EN
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [31:0]   fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q, count_d;
  logic [31:0]   head;
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q, byte_idx_q;
  logic [31:0]   word_q;
  logic [7:0]    byte_q;
  logic          tx_q, busy_q;
  logic          push, pop, bit_end, last_byte;

  assign in_ready  = (count_q < 2'd2);
  assign push      = in_valid && in_ready;
  assign head      = fifo_q[rd_ptr_q];
  assign bit_end   = (cnt_q == CW'(DIV - 1));
  assign last_byte = (byte_idx_q == LAST_BYTE);
  assign tx        = tx_q;
  assign busy      = busy_q;

  // Pop either from idle or at the end of the last stop bit, so back-to-back words have no gap.
  always_comb begin
    pop = 1'b0;
    if (count_q != 2'd0) begin
      if (state_q == IDLE) pop = 1'b1;
      else if (state_q == STOP && bit_end && last_byte) pop = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (!push && pop) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= in_word;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 3'd0;
      word_q     <= 32'd0;
      byte_q     <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pop) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            byte_idx_q <= 3'd0;
            byte_q     <= head[31:24];
            word_q     <= {head[23:0], 8'h00};
          end
        end
        START: if (bit_end) begin
          state_q   <= DATA;
          tx_q      <= byte_q[0];
          byte_q    <= {1'b0, byte_q[7:1]};
          bit_idx_q <= 3'd0;
        end
        DATA: if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            tx_q      <= byte_q[0];
            byte_q    <= {1'b0, byte_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
          end
        end
        STOP: if (bit_end) begin
          if (!last_byte) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            byte_idx_q <= byte_idx_q + 3'd1;
            // Byte index 3 only reaches here when the newline frame is enabled.
            byte_q     <= (byte_idx_q == 3'd3) ? 8'h0A : word_q[31:24];
            word_q     <= {word_q[23:0], 8'h00};
          end else if (pop) begin
            state_q    <= START;
            tx_q       <= 1'b0;
            byte_idx_q <= 3'd0;
            byte_q     <= head[31:24];
            word_q     <= {head[23:0], 8'h00};
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: a scoreboard of expected bytes, fed at each accepted word and drained by a serial receiver.
// A small divider (13) keeps every word frame short.
module tb_uart_word_tx;
  localparam int CLK_HZ = 1300;
  localparam int BAUD   = 100;
  localparam int DIV    = CLK_HZ / BAUD;
`ifdef UART_TX_NEWLINE_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int WCYC = NB * 10 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_word = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_ready, tx, busy;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          nrx = 0;
  logic        rx_en = 1'b0;
  logic [7:0]  sb [$];

  uart_word_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] w);
    for (int i = 0; i < 4; i++) sb.push_back(w[31 - 8*i -: 8]);
`ifdef UART_TX_NEWLINE_EN
    sb.push_back(8'h0A);
`endif
  endtask

  // Receives one frame whose first start-bit cycle is the current negedge.
  task automatic tskRxData();
    logic [7:0] d;
    logic [7:0] exp;
    logic       v;
    logic       shape_ok;
    d = 8'h00;
    shape_ok = 1'b1;
    for (int b = 0; b < 10; b++) begin
      v = tx;
      for (int c = 1; c < DIV; c++) begin
        @(negedge clk);
        if (!rx_en) return;
        if (tx !== v) shape_ok = 1'b0;
      end
      if (b == 0 && v !== 1'b0) shape_ok = 1'b0;
      if (b >= 1 && b <= 8) d[b-1] = v;
      if (b == 9 && v !== 1'b1) shape_ok = 1'b0;
      if (b < 9) begin
        @(negedge clk);
        if (!rx_en) return;
      end
    end
    nrx++;
    if (sb.size() == 0) chk("rx_extra_frame", {24'd0, d}, 32'hFFFF_FFFF);
    else begin
      exp = sb.pop_front();
      chk("rx_byte", {24'd0, d}, {24'd0, exp});
    end
    chk("rx_shape", {31'd0, shape_ok}, 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && tx === 1'b0) tskRxData();
    end
  end

  task automatic send_word(input logic [31:0] w, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_word  = w;
    while (!in_ready && t < 5000) begin @(negedge clk); t++; end
    chk("send_timeout", {31'd0, t >= 5000}, 32'd0);
    sb_push(w);
    acc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    in_word  = $urandom;
  endtask

  task automatic meas_busy(output int n);
    int t;
    t = 0;
    n = 0;
    while (busy !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    while (busy === 1'b1 && n < 20000) begin @(negedge clk); n++; end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && t < 6*WCYC + 200) begin @(negedge clk); t++; end
    chk("idle_timeout", {31'd0, t >= 6*WCYC + 200}, 32'd0);
    repeat (3) @(negedge clk);
  endtask

  int acc [4];
  int nb, n_low, n_busy, a;
  logic [31:0] hw [4];

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    // Idle line with no traffic.
    n_low = 0; n_busy = 0;
    repeat (10000) begin
      @(negedge clk);
      if (tx !== 1'b1) n_low++;
      if (busy !== 1'b0) n_busy++;
    end
    chk("idle_tx_low", n_low, 0);
    chk("idle_busy", n_busy, 0);
    rx_en = 1'b1;

    // Basic word, first-bit latency, busy length.
    send_word(32'h41424344, a);
    chk("lat_tx_pre", {31'd0, tx}, 32'd1);
    chk("lat_busy_pre", {31'd0, busy}, 32'd0);
    meas_busy(nb);
    chk("w1_busy_len", nb, WCYC);
    wait_idle();

    // Start bit width on an alternating byte.
    send_word(32'h55000000, a);
    @(negedge clk);
    chk("t2_tx_fall", {31'd0, tx}, 32'd0);
    n_low = 0;
    while (tx === 1'b0 && n_low < 1000) begin n_low++; @(negedge clk); end
    chk("t2_start_len", n_low, DIV);
    wait_idle();

    // Hold in_valid across four words.
    hw[0] = 32'h30313233; hw[1] = 32'hA5C3_0F81; hw[2] = 32'h7E00_FF18; hw[3] = 32'h4D5A_6B01;
    fork
      begin
        int t;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
          in_valid = 1'b1;
          in_word  = hw[k];
          t = 0;
          while (!in_ready && t < 5000) begin @(negedge clk); t++; end
          chk("hold_timeout", {31'd0, t >= 5000}, 32'd0);
          sb_push(hw[k]);
          acc[k] = cyc + 1;
          @(negedge clk);
        end
        in_valid = 1'b0;
        in_word  = $urandom;
      end
      begin
        meas_busy(nb);
      end
    join
    chk("hold_acc1", acc[1] - acc[0], 1);
    chk("hold_acc2", acc[2] - acc[0], 2);
    chk("hold_acc3", acc[3] - acc[0], 2 + WCYC);
    chk("hold_busy_len", nb, 4*WCYC);
    wait_idle();

    send_word(32'h31323334, a);
    meas_busy(nb);
    chk("t5_busy_len", nb, WCYC);
    wait_idle();

    // Reset during bit 3 of byte 1 (0x42, bit 3 is 0).
    rx_en = 1'b0;
    send_word(32'h41424344, a);
    repeat (14*DIV + DIV/2 + 1) @(negedge clk);
    chk("t4_bit3", {31'd0, tx}, 32'd0);
    chk("t4_busy_mid", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_tx", {31'd0, tx}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    n_low = 0; n_busy = 0;
    repeat (100*DIV) begin
      @(negedge clk);
      if (tx !== 1'b1) n_low++;
      if (busy !== 1'b0) n_busy++;
    end
    chk("t4_tx_quiet", n_low, 0);
    chk("t4_busy_quiet", n_busy, 0);
    sb.delete();
    rx_en = 1'b1;

    send_word(32'h5A0D_7F20, a);
    meas_busy(nb);
    chk("post_rst_busy_len", nb, WCYC);
    wait_idle();

    chk("sb_empty", sb.size(), 0);
    chk("rx_frames", nrx, 8*NB);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
